// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return address stack with flush and checkpoint restore.
//   clk, nreset       clock, synchronous active-low reset (clears ptr/count only)
//   enable            global hold when low (flush/restore included)
//   i_stall           blocks push/pop only
//   i_push/i_push_addr  push a return address (predicted call)
//   i_pop             pop the top entry (predicted return)
//   i_flush           empty the stack, ptr unchanged
//   i_restore/_ptr/_count  reload ptr and occupancy from a checkpoint
//   o_top_addr/o_top_valid  top of stack and non-empty flag
//   o_ptr/o_count     current ptr and occupancy, for checkpointing
module ret_addr_stack #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic                  i_stall,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_push_addr,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic                  i_restore,
    input  logic [DEPTH_LOG2-1:0] i_restore_ptr,
    input  logic [DEPTH_LOG2:0]   i_restore_count,
    output logic [ADDR_WIDTH-1:0] o_top_addr,
    output logic                  o_top_valid,
    output logic [DEPTH_LOG2-1:0] o_ptr,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    logic [ADDR_WIDTH-1:0] entries [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr, ptr_nxt, wr_idx;
    logic [DEPTH_LOG2:0]   count, count_nxt;
    logic nonempty, full, op_ok, do_push, do_pop, replace;
    assign nonempty = count != '0;
    assign full     = count == FULL;
    // flush and restore take the cycle, so any push/pop alongside is dropped
    assign op_ok    = enable & ~i_stall & ~i_flush & ~i_restore;
    assign do_push  = op_ok & i_push;
    assign do_pop   = op_ok & i_pop & nonempty;
    // push+pop on a non-empty stack rewrites the top in place
    assign replace  = do_push & do_pop;
    assign wr_idx   = replace ? ptr : ptr + 1'b1;
    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        if (i_flush) begin
            count_nxt = '0;
        end else if (i_restore) begin
            ptr_nxt   = i_restore_ptr;
            count_nxt = i_restore_count > FULL ? FULL : i_restore_count;
        end else if (do_push && !replace) begin
            ptr_nxt   = ptr + 1'b1;
            count_nxt = full ? count : count + 1'b1;
        end else if (do_pop && !do_push) begin
            ptr_nxt   = ptr - 1'b1;
            count_nxt = count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!nreset) begin
            ptr   <= '0;
            count <= '0;
        end else if (enable) begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
        end
    end
    // entries are not reset; the write is still suppressed during reset
    always_ff @(posedge clk) begin
        if (nreset && do_push)
            entries[wr_idx] <= i_push_addr;
    end
`ifndef SYNTHESIS
    // pushes that overwrote the oldest entry, for statistics
    logic [31:0] overflow_count;
    always_ff @(posedge clk) begin
        if (!nreset)
            overflow_count <= '0;
        else if (do_push && !replace && full)
            overflow_count <= overflow_count + 1'b1;
    end
`endif
    assign o_top_addr  = entries[ptr];
    assign o_top_valid = nonempty;
    assign o_ptr       = ptr;
    assign o_count     = count;
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: scoreboard bench with directed vectors and hand-computed expectations.
module tb_ret_addr_stack;
    logic        clk = 0;
    logic        nreset, enable, i_stall, i_push, i_pop, i_flush, i_restore;
    logic [63:0] i_push_addr;
    logic [2:0]  i_restore_ptr;
    logic [3:0]  i_restore_count;
    logic [63:0] o_top_addr;
    logic        o_top_valid;
    logic [2:0]  o_ptr;
    logic [3:0]  o_count;

    typedef struct {
        string       name;
        bit          chk_addr;
        logic [63:0] addr;
        logic        valid;
        logic [2:0]  ptr;
        logic [3:0]  count;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    ret_addr_stack dut (
        .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
        .i_push(i_push), .i_push_addr(i_push_addr), .i_pop(i_pop),
        .i_flush(i_flush), .i_restore(i_restore), .i_restore_ptr(i_restore_ptr),
        .i_restore_count(i_restore_count), .o_top_addr(o_top_addr),
        .o_top_valid(o_top_valid), .o_ptr(o_ptr), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        nreset = 1; enable = 1; i_stall = 0; i_push = 0; i_pop = 0;
        i_flush = 0; i_restore = 0; i_push_addr = '0; i_restore_ptr = '0; i_restore_count = '0;
    endtask

    // apply current inputs for one edge, then queue the expected post-edge state
    task automatic tick(input string nm, input bit ca, input logic [63:0] a,
                        input logic v, input logic [2:0] p, input logic [3:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = nm; e.chk_addr = ca; e.addr = a; e.valid = v; e.ptr = p; e.count = c;
        sb.push_back(e);
        idle();
    endtask

    task automatic push(input string nm, input logic [63:0] a, input logic [2:0] p, input logic [3:0] c);
        i_push = 1; i_push_addr = a;
        tick(nm, 1, a, 1, p, c);
    endtask

    // monitor: state is stable at the falling edge, compare against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (o_top_valid !== e.valid || o_ptr !== e.ptr || o_count !== e.count ||
                (e.chk_addr && o_top_addr !== e.addr)) begin
                errors++;
                $display("FAIL %s: got valid=%0b ptr=%0d count=%0d top=%h, want valid=%0b ptr=%0d count=%0d top=%h%s",
                         e.name, o_top_valid, o_ptr, o_count, o_top_addr,
                         e.valid, e.ptr, e.count, e.addr, e.chk_addr ? "" : "(unchecked)");
            end
        end
    end

    initial begin
        idle();
        nreset = 0; tick("reset", 0, 0, 0, 0, 0);
        push("push1000", 64'h1000, 1, 1);
        push("push2000", 64'h2000, 2, 2);
        push("push3000", 64'h3000, 3, 3);
        i_push = 1; i_pop = 1; i_push_addr = 64'h4444; tick("pushpop_full", 1, 64'h4444, 1, 3, 3);
        i_pop = 1; tick("pop_a", 1, 64'h2000, 1, 2, 2);
        i_pop = 1; tick("pop_b", 1, 64'h1000, 1, 1, 1);
        i_pop = 1; tick("pop_c", 0, 0, 0, 0, 0);
        i_pop = 1; tick("pop_empty", 0, 0, 0, 0, 0);
        push("push_a0", 64'hA0, 1, 1);
        i_pop = 1; tick("pop_a0", 0, 0, 0, 0, 0);
        i_push = 1; i_pop = 1; i_push_addr = 64'h55; tick("pushpop_empty", 1, 64'h55, 1, 1, 1);
        // overflow: nine pushes into eight entries
        nreset = 0; tick("reset2", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++)
            push($sformatf("ovf_push%0d", k), 64'(k * 'h100), 3'(k), 4'(k > 8 ? 8 : k));
        for (int j = 1; j <= 7; j++) begin
            i_pop = 1; tick($sformatf("ovf_pop%0d", j), 1, 64'((9 - j) * 'h100), 1, 3'(1 - j), 4'(8 - j));
        end
        i_pop = 1; tick("ovf_pop8", 0, 0, 0, 1, 0);
        i_pop = 1; tick("ovf_pop9", 0, 0, 0, 1, 0);
        // checkpoint and restore
        nreset = 0; tick("reset3", 0, 0, 0, 0, 0);
        push("ck_push10", 64'h10, 1, 1);
        push("ck_push20", 64'h20, 2, 2);
        push("ck_push30", 64'h30, 3, 3);
        i_pop = 1; tick("ck_pop1", 1, 64'h20, 1, 2, 2);
        i_pop = 1; tick("ck_pop2", 1, 64'h10, 1, 1, 1);
        i_restore = 1; i_restore_ptr = 2; i_restore_count = 2; tick("restore", 1, 64'h20, 1, 2, 2);
        i_restore = 1; i_restore_ptr = 3; i_restore_count = 3; i_push = 1; i_push_addr = 64'hBAD;
        tick("restore_push", 1, 64'h30, 1, 3, 3);
        i_restore = 1; i_restore_ptr = 5; i_restore_count = 15; tick("restore_sat", 0, 0, 1, 5, 8);
        i_restore = 1; i_restore_ptr = 3; i_restore_count = 3; tick("restore_back", 1, 64'h30, 1, 3, 3);
        // stall, enable and flush
        i_stall = 1; i_push = 1; i_push_addr = 64'h77; tick("stall_push", 1, 64'h30, 1, 3, 3);
        i_stall = 1; i_pop = 1; tick("stall_pop", 1, 64'h30, 1, 3, 3);
        i_stall = 1; i_flush = 1; tick("stall_flush", 0, 0, 0, 3, 0);
        i_restore = 1; i_restore_ptr = 3; i_restore_count = 3; tick("restore_again", 1, 64'h30, 1, 3, 3);
        enable = 0; i_flush = 1; tick("disabled_flush", 1, 64'h30, 1, 3, 3);
        enable = 0; i_push = 1; i_push_addr = 64'h99; tick("disabled_push", 1, 64'h30, 1, 3, 3);
        i_flush = 1; i_push = 1; i_push_addr = 64'h88; tick("flush_push", 0, 0, 0, 3, 0);
        // reset mid-sequence
        nreset = 0; tick("reset4", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            push($sformatf("mid_push%0d", k), 64'(k + 'hE0), 3'(k), 4'(k));
        nreset = 0; i_push = 1; i_push_addr = 64'hF0; tick("reset_mid", 0, 0, 0, 0, 0);
        push("after_reset", 64'hF1, 1, 1);
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
